instr_fetch_unit: RTL and testbench

//  Instruction fetch stage of the 16-bit pipelined CPU: produces the `inst` word consumed by the Ctrl decoder.

---
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and imem.
// Single outstanding request; valid pulses once per accepted req.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic [15:0]       rdata;

    modport master (
        output req,
        output addr,
        input  valid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output valid,
        output rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: fetch PC, single-outstanding imem requests,
// 2-entry prefetch FIFO and execute-stage PC redirects.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [15:0]       NOP_INST = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  imem,
    input  logic                stall,
    input  logic [15:0]         ctrl_exec,
    input  logic                zero,
    input  logic [ADDR_W-1:0]   alu_target,
    input  logic [ADDR_W-1:0]   jump_target,
    output logic [15:0]         inst,
    output logic                inst_valid,
    output logic [ADDR_W-1:0]   pc_out
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [15:0]       data;
        logic [ADDR_W-1:0] addr;
    } fent_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    fent_t             q0;
    fent_t             q1;
    logic [1:0]        cnt;

    logic              esc_cond;
    logic              esc;
    logic [1:0]        fonte;
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              outst;
    logic              rsp;
    logic              push;
    logic              pop;
    logic [1:0]        cnt_nx;
    logic              issue;
    fent_t             rsp_ent;
    logic              unused_ctrl;

    assign esc_cond = ctrl_exec[0];
    assign esc      = ctrl_exec[1];
    assign fonte    = ctrl_exec[7:6];
    assign unused_ctrl = ^{ctrl_exec[15:8], ctrl_exec[5:2]};

    assign redirect = esc & ((fonte == 2'b10) |
                      ((fonte == 2'b01) & esc_cond & zero));
    assign target   = fonte[1] ? jump_target : alu_target;

    assign outst   = (state != IDLE);
    assign rsp     = imem.valid & (state == WAIT);
    assign push    = rsp & ~redirect;
    assign pop     = ~redirect & ~stall & (cnt != 2'd0);
    assign cnt_nx  = cnt + {1'b0, push} - {1'b0, pop};
    // Room is judged after this edge's pop/push so a full FIFO
    // being drained can refill without a bubble.
    assign issue   = ~redirect & (cnt_nx != 2'd2) &
                     ((state == IDLE) | rsp);
    assign rsp_ent = {imem.rdata, imem.addr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            cnt        <= 2'd0;
            q0         <= '0;
            q1         <= '0;
            imem.req   <= 1'b0;
            imem.addr  <= '0;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            pc_out     <= '0;
        end else begin
            imem.req <= issue;
            if (issue) begin
                imem.addr <= fetch_pc;
            end

            if (redirect) begin
                fetch_pc <= target;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 1'b1;
            end

            if (issue) begin
                state <= WAIT;
            end else if (redirect) begin
                // A pending response with no strobe yet must be eaten.
                state <= (outst & ~imem.valid) ? DRAIN : IDLE;
            end else begin
                unique case (state)
                    WAIT:    if (imem.valid) state <= IDLE;
                    DRAIN:   if (imem.valid) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end

            if (redirect) begin
                cnt <= 2'd0;
            end else begin
                cnt <= cnt_nx;
                if (pop) begin
                    q0 <= (push && cnt == 2'd1) ? rsp_ent : q1;
                end else if (push) begin
                    if (cnt == 2'd0) q0 <= rsp_ent;
                    else             q1 <= rsp_ent;
                end
            end

            if (redirect) begin
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
            end else if (!stall) begin
                if (cnt != 2'd0) begin
                    inst       <= q0.data;
                    pc_out     <= q0.addr;
                    inst_valid <= 1'b1;
                end else begin
                    inst       <= NOP_INST;
                    inst_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: program-order model of
// the decode stream plus a latency-configurable memory model.
module tb_instr_fetch_unit;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [15:0] ctrl_exec;
    logic        zero;
    logic [7:0]  alu_target;
    logic [7:0]  jump_target;
    logic [15:0] inst;
    logic        inst_valid;
    logic [7:0]  pc_out;

    instr_fetch_unit_if #(.ADDR_W(8)) imem ();

    instr_fetch_unit #(
        .ADDR_W  (8),
        .RESET_PC(8'h00),
        .NOP_INST(16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (imem),
        .stall      (stall),
        .ctrl_exec  (ctrl_exec),
        .zero       (zero),
        .alu_target (alu_target),
        .jump_target(jump_target),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc_out     (pc_out)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          pops     = 0;
    logic [15:0] mem [256];
    exp_t        exp_q [$];
    int          cur_lat  = 1;
    bit          spur_en  = 0;
    bit          pend     = 0;
    int          pcnt     = 0;
    logic [7:0]  paddr;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic bit model_redirect(logic [15:0] c, logic z);
        bit is_jump;
        bit is_taken_branch;
        is_jump         = c[1] && (c[7:6] == 2'b10);
        is_taken_branch = c[1] && (c[7:6] == 2'b01) && c[0] && z;
        return is_jump || is_taken_branch;
    endfunction

    task automatic restart(logic [7:0] pc);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 260; i++) begin
            e.pc   = pc + 8'(i);
            e.data = mem[e.pc];
            exp_q.push_back(e);
        end
    endtask

    // Monitor + scoreboard + memory model
    initial begin
        bit         e_rst, e_stall, e_redir;
        logic [7:0] e_tgt;
        logic [7:0] req_next;
        bit         hold_known;
        bit         exp_valid;
        exp_t       cur;
        exp_t       it;
        req_next   = 8'h00;
        hold_known = 0;
        exp_valid  = 0;
        cur.pc     = 8'h00;
        cur.data   = 16'h0000;
        imem.valid = 1'b0;
        imem.rdata = 16'h0000;
        forever begin
            @(posedge clk);
            e_rst   = rst;
            e_stall = stall;
            e_redir = model_redirect(ctrl_exec, zero);
            e_tgt   = (ctrl_exec[7:6] == 2'b10) ? jump_target : alu_target;
            @(negedge clk);
            if (e_rst) begin
                chk("rst_req", imem.req, 0);
                chk("rst_addr", imem.addr, 0);
                chk("rst_inst", inst, 16'h0000);
                chk("rst_valid", inst_valid, 0);
                chk("rst_pc", pc_out, 0);
                restart(8'h00);
                req_next   = 8'h00;
                hold_known = 1;
                exp_valid  = 0;
            end else if (e_redir) begin
                chk("redir_valid", inst_valid, 0);
                chk("redir_noreq", imem.req, 0);
                restart(e_tgt);
                req_next   = e_tgt;
                hold_known = 1;
                exp_valid  = 0;
            end else begin
                if (imem.req) begin
                    chk("req_addr", imem.addr, req_next);
                    req_next = req_next + 8'd1;
                end
                if (e_stall) begin
                    if (hold_known) begin
                        chk("hold_valid", inst_valid, exp_valid);
                        if (exp_valid) begin
                            chk("hold_pc", pc_out, cur.pc);
                            chk("hold_inst", inst, cur.data);
                        end
                    end
                end else if (inst_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_empty", 1, 0);
                    end else begin
                        it = exp_q.pop_front();
                        chk("inst_pc", pc_out, it.pc);
                        chk("inst_data", inst, it.data);
                        cur        = it;
                        exp_valid  = 1;
                        hold_known = 1;
                        pops++;
                    end
                end else begin
                    hold_known = 0;
                end
            end
            imem.valid = 1'b0;
            if (pend) begin
                pcnt--;
                if (pcnt == 0) begin
                    imem.valid = 1'b1;
                    imem.rdata = mem[paddr];
                    pend       = 0;
                end
            end
            if (imem.req && !e_rst) begin
                if (pend) chk("single_outstanding", 1, 0);
                pend  = 1;
                paddr = imem.addr;
                pcnt  = cur_lat - 1;
                if (pcnt == 0) begin
                    imem.valid = 1'b1;
                    imem.rdata = mem[paddr];
                    pend       = 0;
                end
            end else if (!pend && !imem.valid && spur_en &&
                         ($urandom % 8 == 0)) begin
                imem.valid = 1'b1;
                imem.rdata = 16'($urandom);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(string nm, int lim);
        int n = 0;
        while (!inst_valid && n < lim) begin
            step();
            n++;
        end
        chk(nm, inst_valid, 1);
    endtask

    task automatic wait_req(string nm, int lim);
        int n = 0;
        while (!imem.req && n < lim) begin
            step();
            n++;
        end
        chk(nm, imem.req, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    // Stimulus
    initial begin
        int r;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        rst         = 1'b1;
        stall       = 1'b0;
        ctrl_exec   = 16'h0000;
        zero        = 1'b0;
        alu_target  = 8'h00;
        jump_target = 8'h00;
        repeat (3) step();
        rst = 1'b0;

        wait_valid("t1_first", 20);
        chk("t1_first_pc", pc_out, 8'h00);
        chk("t1_first_inst", inst, 16'h1000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_thruput", inst_valid, 1);
        end

        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i >= 2) chk("t2_full_noreq", imem.req, 0);
        end
        stall = 1'b0;
        repeat (3) step();

        ctrl_exec   = 16'h5896;
        jump_target = 8'h40;
        step();
        ctrl_exec = 16'h0000;
        chk("t3_squash", inst_valid, 0);
        wait_valid("t3_wait", 20);
        chk("t3_pc", pc_out, 8'h40);
        chk("t3_inst", inst, 16'h1040);
        repeat (2) step();

        ctrl_exec  = 16'h6047;
        zero       = 1'b0;
        alu_target = 8'h20;
        step();
        ctrl_exec = 16'h0000;
        repeat (3) step();
        ctrl_exec = 16'h6047;
        zero      = 1'b1;
        step();
        ctrl_exec = 16'h0000;
        zero      = 1'b0;
        chk("t4_squash", inst_valid, 0);
        wait_valid("t4_wait", 20);
        chk("t4_pc", pc_out, 8'h20);
        chk("t4_inst", inst, 16'h1020);

        cur_lat = 3;
        step();
        wait_req("t5_req", 20);
        ctrl_exec   = 16'h5896;
        jump_target = 8'h80;
        step();
        ctrl_exec = 16'h0000;
        wait_valid("t5_wait", 30);
        chk("t5_pc", pc_out, 8'h80);
        chk("t5_inst", inst, 16'h1080);

        stall = 1'b1;
        wait_req("t6_req", 20);
        rst = 1'b1;
        step();
        chk("t6_valid", inst_valid, 0);
        chk("t6_inst", inst, 16'h0000);
        chk("t6_pc", pc_out, 8'h00);
        step();
        rst   = 1'b0;
        stall = 1'b0;
        wait_valid("t6_wait", 30);
        chk("t6_restart_pc", pc_out, 8'h00);
        chk("t6_restart_inst", inst, 16'h1000);

        rst = 1'b1;
        for (int n = 0; n < 20 && pend; n++) step();
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        repeat (2) step();
        rst     = 1'b0;
        spur_en = 1;
        pops    = 0;
        for (int c = 0; c < 3000; c++) begin
            stall   = ($urandom % 4 == 0);
            cur_lat = $urandom_range(1, 4);
            zero    = 1'($urandom);
            r       = $urandom % 32;
            if (r == 0) begin
                ctrl_exec   = 16'($urandom);
                alu_target  = 8'($urandom);
                jump_target = 8'($urandom);
            end else if (r == 1) begin
                ctrl_exec   = (16'($urandom) & ~16'h00C2) | 16'h0082;
                jump_target = 8'hFE;
            end else begin
                ctrl_exec = 16'($urandom) & ~16'h0002;
            end
            step();
        end
        ctrl_exec = 16'h0000;
        stall     = 1'b0;
        spur_en   = 0;
        repeat (20) step();
        chk("rand_progress", (pops >= 200) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
